// File: rtl/rv_cycle_controller.sv
// rv_cycle_controller
//   Multi-cycle control FSM for a small RISC-V style datapath. It steps
//   IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and issues the
//   datapath strobes for each step. It counts retired instructions and
//   flags illegal opcodes.
//
// Ports
//   clk           : clock; all state changes on the rising edge
//   rst           : synchronous active-high reset
//   start         : leave IDLE and begin fetching (ignored elsewhere)
//   opcode[6:0]   : instruction opcode from the IR, sampled in DECODE
//   mem_ack       : memory finished the current request this cycle
//   S[2:0]        : current state (registered)
//   NS[2:0]       : next state (combinational)
//   mem_req       : memory request (FETCH, MEM)
//   mem_we        : memory write (MEM for STORE only)
//   ir_we         : instruction register write
//   pc_we         : program counter write
//   rf_we         : register file write
//   pc_src_branch : PC source select = branch target
//   done          : controller halted
//   err           : illegal opcode seen (sticky until rst)
//   instr_count   : retired instructions, saturating

module rv_cycle_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [6:0]       opcode,
  input  logic             mem_ack,
  output logic [2:0]       S,
  output logic [2:0]       NS,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic             pc_src_branch,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_BAD    = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CL_R       = 3'd0,
    CL_I       = 3'd1,
    CL_LOAD    = 3'd2,
    CL_STORE   = 3'd3,
    CL_BRANCH  = 3'd4,
    CL_SYSTEM  = 3'd5,
    CL_ILLEGAL = 3'd6
  } cls_e;

  // Map a raw opcode onto the instruction class the FSM steers by.
  function automatic cls_e decode_class(input logic [6:0] op);
    cls_e c;
    case (op)
      7'b0110011: c = CL_R;
      7'b0010011: c = CL_I;
      7'b0000011: c = CL_LOAD;
      7'b0100011: c = CL_STORE;
      7'b1100011: c = CL_BRANCH;
      7'b1110011: c = CL_SYSTEM;
      default:    c = CL_ILLEGAL;
    endcase
    return c;
  endfunction

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire_s;

  // Next-state, strobe and bookkeeping logic.
  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    err_d         = err_q;
    retire_s      = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    rf_we         = 1'b0;
    pc_src_branch = 1'b0;
    done          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FETCH: begin
        // mem_req stays up until the memory acknowledges.
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_DECODE: begin
        // The class is captured here so later states do not depend on the
        // IR still holding the same opcode.
        cls_d = decode_class(opcode);
        case (cls_d)
          CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH: state_d = ST_EXEC;
          CL_SYSTEM:                                state_d = ST_HALT;
          default: begin
            state_d = ST_HALT;
            err_d   = 1'b1;
          end
        endcase
      end

      ST_EXEC: begin
        case (cls_q)
          CL_R, CL_I:        state_d = ST_WB;
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          CL_BRANCH: begin
            pc_we         = 1'b1;
            pc_src_branch = 1'b1;
            retire_s      = 1'b1;
            state_d       = ST_FETCH;
          end
          default: begin
            // Only reachable through a corrupted class register.
            state_d = ST_HALT;
            err_d   = 1'b1;
          end
        endcase
      end

      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls_q == CL_STORE);
        if (!mem_ack) begin
          state_d = ST_MEM;
        end else if (cls_q == CL_STORE) begin
          pc_we    = 1'b1;
          retire_s = 1'b1;
          state_d  = ST_FETCH;
        end else if (cls_q == CL_LOAD) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end
      end

      ST_WB: begin
        rf_we    = 1'b1;
        pc_we    = 1'b1;
        retire_s = 1'b1;
        state_d  = ST_FETCH;
      end

      ST_HALT: begin
        done    = 1'b1;
        state_d = ST_HALT;
      end

      default: begin
        // Code 7 is never entered legitimately; park in HALT and flag it.
        state_d = ST_HALT;
        err_d   = 1'b1;
      end
    endcase

    // Retired-instruction counter saturates at all-ones.
    if (retire_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, class, error and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cls_q   <= CL_R;
      err_q   <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign S           = state_q;
  assign NS          = state_d;
  assign err         = err_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_rv_cycle_controller.sv
// Self-checking bench for rv_cycle_controller (CNT_W = 4).
// A transaction-level model expands each instruction into its expected
// per-cycle trace from the latency and strobe rules; a compare process
// checks every queued cycle at the falling edge.

module tb_rv_cycle_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic [6:0] opcode;
  logic       mem_ack;
  logic [2:0] S;
  logic [2:0] NS;
  logic       mem_req, mem_we, ir_we, pc_we, rf_we, pc_src_branch;
  logic       done, err;
  logic [3:0] instr_count;

  rv_cycle_controller #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .mem_ack(mem_ack),
    .S(S), .NS(NS), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
    .pc_we(pc_we), .rf_we(rf_we), .pc_src_branch(pc_src_branch),
    .done(done), .err(err), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] s;
    logic [2:0] ns;
    bit         chk_ns;
    logic       req, we, irw, pcw, rfw, br, dn, er;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_vec = 0;
  int   n_bad = 0;
  int   m_cnt = 0;
  bit   m_err = 1'b0;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_SYS = 7'b1110011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, want);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] s, input logic [2:0] ns, input bit cn,
                              input bit req, input bit we, input bit irw, input bit pcw,
                              input bit rfw, input bit br, input bit dn);
    exp_t e;
    e.s = s; e.ns = ns; e.chk_ns = cn;
    e.req = req; e.we = we; e.irw = irw; e.pcw = pcw; e.rfw = rfw; e.br = br;
    e.dn = dn; e.er = m_err; e.cnt = 4'(m_cnt);
    return e;
  endfunction

  function automatic void retire();
    if (m_cnt < 15) m_cnt = m_cnt + 1;
  endfunction

  // One clock cycle: apply mem_ack, queue the expectation, advance.
  task automatic cyc(input logic ack, input exp_t e);
    mem_ack = ack;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Instruction kind: 0 ALU, 1 load, 2 store, 3 branch, 4 system, 5 illegal.
  function automatic int kind(input logic [6:0] op);
    if (op == OP_R || op == OP_I) return 0;
    if (op == OP_LD)  return 1;
    if (op == OP_ST)  return 2;
    if (op == OP_BR)  return 3;
    if (op == OP_SYS) return 4;
    return 5;
  endfunction

  // Expand one instruction (starting in FETCH) into its cycle trace.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                           input bit abort, output int cycles);
    int k;
    k = kind(op);
    cycles = 0;
    opcode = op;
    for (int i = 0; i < fw; i++) begin
      cyc(1'b0, mk(3'd1, 3'd1, 1, 1, 0, 0, 0, 0, 0, 0)); cycles++;
    end
    cyc(1'b1, mk(3'd1, 3'd2, 1, 1, 0, 1, 0, 0, 0, 0)); cycles++;
    if (k >= 4) begin
      cyc(1'b1, mk(3'd2, 3'd6, 1, 0, 0, 0, 0, 0, 0, 0)); cycles++;
      if (k == 5) m_err = 1'b1;
      return;
    end
    cyc(1'b1, mk(3'd2, 3'd3, 1, 0, 0, 0, 0, 0, 0, 0)); cycles++;
    opcode = OP_BAD;  // later steps must rely on the class captured in DECODE
    if (k == 3) begin
      cyc(1'b1, mk(3'd3, 3'd1, 1, 0, 0, 0, 1, 0, 1, 0)); cycles++;
      retire();
      return;
    end
    if (k == 0) begin
      cyc(1'b1, mk(3'd3, 3'd5, 1, 0, 0, 0, 0, 0, 0, 0)); cycles++;
    end else begin
      cyc(1'b1, mk(3'd3, 3'd4, 1, 0, 0, 0, 0, 0, 0, 0)); cycles++;
      if (abort) begin
        rst = 1'b1;
        cyc(1'b0, mk(3'd4, 3'd4, 0, 1, (k == 2), 0, 0, 0, 0, 0)); cycles++;
        rst = 1'b0;
        m_cnt = 0;
        m_err = 1'b0;
        return;
      end
      for (int i = 0; i < mw; i++) begin
        cyc(1'b0, mk(3'd4, 3'd4, 1, 1, (k == 2), 0, 0, 0, 0, 0)); cycles++;
      end
      if (k == 2) begin
        cyc(1'b1, mk(3'd4, 3'd1, 1, 1, 1, 0, 1, 0, 0, 0)); cycles++;
        retire();
        return;
      end
      cyc(1'b1, mk(3'd4, 3'd5, 1, 1, 0, 0, 0, 0, 0, 0)); cycles++;
    end
    cyc(1'b1, mk(3'd5, 3'd1, 1, 0, 0, 0, 1, 1, 0, 0)); cycles++;
    retire();
  endtask

  task automatic halt_cycles(input int n, input bit pulse);
    for (int i = 0; i < n; i++) begin
      start = pulse && (i == 1);
      cyc(1'b1, mk(3'd6, 3'd6, 1, 0, 0, 0, 0, 0, 0, 1));
    end
    start = 1'b0;
  endtask

  task automatic do_reset(input logic st);
    rst = 1'b1;
    start = st;
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    cyc(1'b0, mk(3'd0, 3'd1, 1, 0, 0, 0, 0, 0, 0, 0));
    start = 1'b0;
  endtask

  // Compare DUT outputs against the queued expectation mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      chk("S", 32'(S), 32'(cur.s));
      if (cur.chk_ns) chk("NS", 32'(NS), 32'(cur.ns));
      chk("mem_req", 32'(mem_req), 32'(cur.req));
      chk("mem_we", 32'(mem_we), 32'(cur.we));
      chk("ir_we", 32'(ir_we), 32'(cur.irw));
      chk("pc_we", 32'(pc_we), 32'(cur.pcw));
      chk("rf_we", 32'(rf_we), 32'(cur.rfw));
      chk("pc_src_branch", 32'(pc_src_branch), 32'(cur.br));
      chk("done", 32'(done), 32'(cur.dn));
      chk("err", 32'(err), 32'(cur.er));
      chk("instr_count", 32'(instr_count), 32'(cur.cnt));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; mem_ack = 1'b0; opcode = OP_R;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_S", 32'(S), 32'd0);
    chk("reset_cnt", 32'(instr_count), 32'd0);
    cyc(1'b0, mk(3'd0, 3'd0, 1, 0, 0, 0, 0, 0, 0, 0));
    kick();

    run_instr(OP_R, 0, 0, 0, lat);
    chk("lat_R", 32'(lat), 32'd4);
    chk("cnt_after_R", 32'(instr_count), 32'd1);

    start = 1'b1;  // must be ignored outside IDLE
    run_instr(OP_I, 2, 0, 0, lat);
    start = 1'b0;
    chk("lat_I_2waits", 32'(lat), 32'd6);

    run_instr(OP_LD, 0, 3, 0, lat);
    chk("lat_LOAD_3waits", 32'(lat), 32'd8);
    run_instr(OP_ST, 0, 0, 0, lat);
    chk("lat_STORE", 32'(lat), 32'd4);
    run_instr(OP_BR, 0, 0, 0, lat);
    chk("lat_BRANCH", 32'(lat), 32'd3);
    chk("cnt_after_5", 32'(instr_count), 32'd5);

    run_instr(OP_SYS, 0, 0, 0, lat);
    halt_cycles(3, 1'b1);
    chk("sys_S", 32'(S), 32'd6);
    chk("sys_err", 32'(err), 32'd0);
    chk("sys_cnt", 32'(instr_count), 32'd5);

    do_reset(1'b1);
    cyc(1'b0, mk(3'd0, 3'd0, 1, 0, 0, 0, 0, 0, 0, 0));
    kick();
    run_instr(OP_BAD, 1, 0, 0, lat);
    halt_cycles(2, 1'b1);
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_done", 32'(done), 32'd1);
    do_reset(1'b1);
    chk("post_rst_S", 32'(S), 32'd0);
    chk("post_rst_err", 32'(err), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);
    cyc(1'b0, mk(3'd0, 3'd0, 1, 0, 0, 0, 0, 0, 0, 0));

    kick();
    for (int i = 0; i < 17; i++) run_instr(OP_BR, 0, 0, 0, lat);
    chk("sat_cnt", 32'(instr_count), 32'd15);

    run_instr(OP_LD, 0, 0, 1, lat);
    chk("abort_S", 32'(S), 32'd0);
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    cyc(1'b0, mk(3'd0, 3'd0, 1, 0, 0, 0, 0, 0, 0, 0));
    cyc(1'b0, mk(3'd0, 3'd0, 1, 0, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_cycle_controller.md
RV_CYCLE_CONTROLLER -- requirements
Module: rv_cycle_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of retired-instruction counter.
REQ-002 SHALL have port clk  input  1  the only clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  begin execution from IDLE.
REQ-005 SHALL have port opcode  input  7  instruction bits [6:0] from datapath IR, valid in DECODE.
REQ-006 SHALL have port mem_ack  input  1  memory completed the current request this cycle.
REQ-007 SHALL have port S  output  3  current state; NS  output  3  next state (combinational).
REQ-008 SHALL have ports mem_req, mem_we, ir_we, pc_we, rf_we, pc_src_branch  output  1 each  datapath strobes.
REQ-009 SHALL have ports done  output  1  halted; err  output  1  illegal opcode seen; instr_count  output  CNT_W  retired instructions.

Function
REQ-010 SHALL encode states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; code 7 unreachable, SHALL go to HALT with err=1 if entered.
REQ-011 SHALL register S; NS and all strobes SHALL be combinational from S, latched opcode class, mem_ack.
REQ-012 IDLE: all strobes 0; start=1 -> FETCH, else stay.
REQ-013 FETCH: mem_req=1, mem_we=0; mem_ack=0 -> stay (mem_req held); mem_ack=1 -> ir_we=1 same cycle, -> DECODE.
REQ-014 DECODE: SHALL latch opcode class into internal register; 0110011 R, 0010011 I, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH -> EXEC; 1110011 SYSTEM -> HALT; any other -> HALT and set err=1.
REQ-015 EXEC: R/I -> WB; LOAD/STORE -> MEM; BRANCH -> pc_we=1, pc_src_branch=1, instr_count+1, -> FETCH.
REQ-016 MEM: mem_req=1, mem_we=1 only for STORE; mem_ack=0 -> stay; ack with LOAD -> WB; ack with STORE -> pc_we=1, instr_count+1, -> FETCH.
REQ-017 WB: rf_we=1, pc_we=1, instr_count+1, -> FETCH.
REQ-018 HALT: done=1, all other strobes 0; SHALL remain until rst; start ignored.
REQ-019 start SHALL be ignored in every state except IDLE.
REQ-020 Latency with mem_ack tied 1: R/I 4 cycles, LOAD 5, STORE 4, BRANCH 3 (FETCH entry to next FETCH entry).
REQ-021 Each added mem_ack=0 cycle in FETCH or MEM SHALL add exactly one cycle.
REQ-022 instr_count SHALL saturate at all-ones; no wrap.
REQ-023 At most one of ir_we, pc_we, rf_we SHALL be asserted in IDLE/FETCH/DECODE; pc_we and rf_we together only in WB.
REQ-024 err SHALL be sticky until rst.

Reset
REQ-025 rst=1 at an edge SHALL force S=IDLE, instr_count=0, err=0, latched class=R, regardless of state or mem_ack.
REQ-026 After that edge all strobes and done SHALL be 0; rst SHALL override start in the same cycle.
REQ-027 rst mid-FETCH/MEM SHALL drop mem_req the cycle after the reset edge; no pc_we/rf_we/ir_we that cycle.

Verification
REQ-028 rst 2 cycles, start=1, mem_ack=1, opcode=0110011 -> S sequence 0,1,2,3,5,1; rf_we and pc_we high 1 cycle in WB; instr_count=1.
REQ-029 opcode=0000011, mem_ack low 3 cycles in MEM -> MEM held 4 cycles, mem_we=0, then WB; total 8 cycles; instr_count=1.
REQ-030 opcode=0100011, ack=1 -> S 1,2,3,4,1; mem_we=1 in MEM only; rf_we never high.
REQ-031 opcode=1110011 after one R instr -> S reaches 6, done=1, err=0, instr_count=1; start pulse in HALT -> no change.
REQ-032 opcode=1111111 -> HALT with err=1, done=1; then rst -> S=0, err=0, done=0.
REQ-033 Force instr_count near max (CNT_W=4, 17 BRANCH instrs) -> count holds at 15; rst during MEM with ack=0 -> S=0, mem_req=0 next cycle.
